// File: rtl/load_access_seq.sv
// ============================================================================
//  Module   : load_access_seq
//  Purpose  : Multi-cycle data-memory load sequencer: one or two word reads,
//             byte merge, sign/zero extension, pipeline stall until done.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module load_access_seq #(
  parameter int MEM_LAT = 1
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [2:0]  load_type,
  output logic        mem_rd_en,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        load_err
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LW  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_WAIT0  = 3'd2,
    S_ISSUE1 = 3'd3,
    S_WAIT1  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e        state_q;
  logic          mem_rd_en_q;
  logic [29:0]   mem_addr_q;
  logic          load_valid_q;
  logic          load_err_q;
  logic [31:0]   load_data_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    off_q;
  logic [2:0]    type_q;
  logic [31:0]   lo_q;

  logic          legal_d;
  logic [3:0]    size_d;
  logic          split_d;
  logic [31:0]   merge_lo_d;
  logic [31:0]   merge_hi_d;
  logic [31:0]   shifted_d;
  logic [31:0]   data_d;

  assign legal_d = (load_type >= LT_LB) && (load_type <= LT_LHU);

  always_comb begin
    size_d = 4'd4;
    case (type_q)
      LT_LB, LT_LBU: size_d = 4'd1;
      LT_LH, LT_LHU: size_d = 4'd2;
      default:       size_d = 4'd4;
    endcase
  end

  assign split_d = ({2'b00, off_q} + size_d) > 4'd4;

  // In WAIT1 the low word was captured earlier and the arriving word is the high one.
  assign merge_lo_d = (state_q == S_WAIT1) ? lo_q : mem_rdata;
  assign merge_hi_d = (state_q == S_WAIT1) ? mem_rdata : 32'd0;
  assign shifted_d  = 32'({merge_hi_d, merge_lo_d} >> {off_q, 3'b000});

  always_comb begin
    data_d = 32'd0;
    case (type_q)
      LT_LB:   data_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
      LT_LBU:  data_d = {24'd0, shifted_d[7:0]};
      LT_LH:   data_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
      LT_LHU:  data_d = {16'd0, shifted_d[15:0]};
      LT_LW:   data_d = shifted_d;
      default: data_d = 32'd0;
    endcase
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_q      <= S_IDLE;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      load_valid_q <= 1'b0;
      load_err_q   <= 1'b0;
      load_data_q  <= '0;
      cnt_q        <= '0;
      off_q        <= '0;
      type_q       <= '0;
      lo_q         <= '0;
    end else begin
      mem_rd_en_q  <= 1'b0;
      load_valid_q <= 1'b0;
      load_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            off_q  <= addr[1:0];
            type_q <= load_type;
            if (legal_d) begin
              state_q     <= S_ISSUE0;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= addr[31:2];
            end else begin
              state_q      <= S_DONE;
              load_valid_q <= 1'b1;
              load_err_q   <= 1'b1;
              load_data_q  <= '0;
            end
          end
        end
        S_ISSUE0: begin
          state_q <= S_WAIT0;
          cnt_q   <= CNT_LOAD;
        end
        S_WAIT0: begin
          if (cnt_q == '0) begin
            lo_q <= mem_rdata;
            if (split_d) begin
              state_q     <= S_ISSUE1;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= mem_addr_q + 30'd1;
            end else begin
              state_q      <= S_DONE;
              load_valid_q <= 1'b1;
              load_data_q  <= data_d;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_ISSUE1: begin
          state_q <= S_WAIT1;
          cnt_q   <= CNT_LOAD;
        end
        S_WAIT1: begin
          if (cnt_q == '0) begin
            state_q      <= S_DONE;
            load_valid_q <= 1'b1;
            load_data_q  <= data_d;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall      = (state_q == S_IDLE) ? req : (state_q != S_DONE);
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign load_err   = load_err_q;

endmodule

`default_nettype wire
